prbs26_checker: RTL
===================

# prbs26_checker

Serial receive-side checker for the 26-bit Galois LFSR sequence generator. It consumes the generator's serial output (one bit per valid cycle) and self-synchronises to the sequence without a seed exchange. After lock it flywheels on its own prediction and counts bit errors for link BER measurement. It sits at the far end of the test link, opposite the LFSR source.

## Interface
- `LOCK_CNT`, 32: consecutive correct predictions required to declare lock.
- `ERR_WIN`, 256: loss-of-lock observation window, in valid bits.
- `ERR_THRESH`, 8: errors within one window that force loss of lock.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din_valid` in 1: `din` carries a sequence bit this cycle.
- `din` in 1: received bit, equal to the generator's q[26] on its shift cycle.
- `clr_cnt` in 1: synchronous clear of `err_cnt` and `bit_cnt`.
- `locked` out 1: checker is in LOCKED.
- `err` out 1: one-cycle pulse; the previous valid bit mismatched while LOCKED.
- `err_cnt` out 32: saturating count of errors seen while LOCKED.
- `bit_cnt` out 32: saturating count of valid bits checked while LOCKED.

## Operation
- Sequence law: the generator polynomial is x^26+x^8+x^7+x+1, with feedback into stages 1, 2, 8 and 9. Its output obeys `o[n] = o[n-26] ^ o[n-25] ^ o[n-19] ^ o[n-18]`.
- History register `h[1:26]`: `h[1]` holds the newest bit. The prediction is `p = h[26]^h[25]^h[19]^h[18]`. The register shifts only on `din_valid`.
- FSM states:
  - FILL: shift `din` into `h` and count to 26. Then go to ACQ with the match counter cleared.
  - ACQ: shift `din` into `h`.
    - `din==p` and `h != 0`: increment the match counter.
    - Otherwise: clear the match counter.
    - Match counter reaches `LOCK_CNT`: go to LOCKED and clear the window and window-error counters.
  - LOCKED (flywheel): shift `p`, not `din`, into `h`, so one line error is counted exactly once.
    - `din != p`: pulse `err`, increment `err_cnt`, and increment the window-error counter.
    - Each valid bit increments `bit_cnt` and the window counter.
    - Window counter reaches `ERR_WIN`: clear both window counters.
    - Window-error counter reaches `ERR_THRESH`: go to FILL and clear `h` and all FSM counters. `err_cnt` and `bit_cnt` are not cleared.
- All-zero input never locks: the `h != 0` guard in ACQ prevents it.
- Counters saturate at 2^32-1.
- `clr_cnt` takes priority over a same-cycle increment: the result is 0.
- `clr_cnt` does not affect the FSM.

## Timing
- Reset values: state FILL, `h`=0, `locked`=0, `err`=0, `err_cnt`=0, `bit_cnt`=0, and all internal counters 0.
- All outputs are registered. `err`, `locked` and the counter updates appear on the edge that samples the offending or qualifying bit, so they are visible the next cycle.
- Minimum lock latency from reset on a clean stream is 26 + `LOCK_CNT` valid bits. `locked` rises on the edge sampling bit index 25+`LOCK_CNT`, counting from 0.
- Loss of lock: `locked` falls on the edge sampling the `ERR_THRESH`-th windowed error. `err` also pulses for that bit.
- Window rollover and threshold in the same cycle: the threshold wins and lock is dropped.
- `din_valid` low: no state, counter or output change, and `err` is 0.
- Mid-operation `rst_n` assertion returns to reset values immediately, without waiting for a clock. Deassertion is synchronised externally.

## Structure
- Shared package `prbs26_pkg`:
  - `PRBS26_LEN`=26.
  - Tap constants 26, 25, 19, 18.
  - FSM enum `{FILL, ACQ, LOCKED}`.
- Sub-module `prbs26_pred`: the history register, the predictor, the shift source mux (`din` or `p`) and the non-zero flag.
- The top level holds the FSM and counters.

## Test plan
- Generator seeded 26'b1, driving 100 bits with `din_valid`=1 → `locked`=1 on bit 57; `err_cnt`=0 and `bit_cnt`=42 after bit 99.
- Locked stream, invert one bit → exactly one `err` pulse and `err_cnt`=1. Lock is held, and no further errors appear (flywheel).
- Locked stream, 8 inverted bits within 256 → `locked`=0 on the edge sampling the 8th error. The checker then relocks 58 bits later and `err_cnt` stays 8.
- Constant `din`=0 for 500 bits → `locked` never rises.
- Locked stream with `din_valid` toggling 1/0 → same lock and count results as the contiguous stream. `err` is never asserted on invalid cycles.
- Assert `clr_cnt` while an error occurs → `err_cnt`=0. Pulse `rst_n` low mid-lock → all outputs read 0 before the next edge.

Source files
------------

// File: rtl/prbs26_pkg.sv
// prbs26_pkg: shared constants, FSM states and helpers for the PRBS26 checker.
package prbs26_pkg;
   localparam int PRBS26_LEN = 26;
   localparam int TAP_A = 26;
   localparam int TAP_B = 25;
   localparam int TAP_C = 19;
   localparam int TAP_D = 18;
   typedef enum logic [1:0] {FILL, ACQ, LOCKED} state_e;
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return &v ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/prbs26_pred.sv
// prbs26_pred: history register and next-bit predictor for the PRBS26 recurrence.
module prbs26_pred
   import prbs26_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic shift_i,
   input  logic clear_i,
   input  logic sel_p_i,
   input  logic din_i,
   output logic p_o,
   output logic nz_o
);
   logic [PRBS26_LEN:1] h_q;
   assign p_o  = h_q[TAP_A] ^ h_q[TAP_B] ^ h_q[TAP_C] ^ h_q[TAP_D];
   assign nz_o = |h_q;
   // h[1] is the newest bit; in flywheel mode the prediction is fed back instead of din
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) h_q <= '0;
      else if (clear_i) h_q <= '0;
      else if (shift_i) h_q <= {h_q[PRBS26_LEN-1:1], sel_p_i ? p_o : din_i};
   end
endmodule

// File: rtl/prbs26_checker.sv
// prbs26_checker: self-synchronising PRBS26 receive checker with flywheel lock,
// windowed loss-of-lock detection and saturating error/bit counters.
module prbs26_checker
   import prbs26_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 32,
   parameter int unsigned ERR_WIN    = 256,
   parameter int unsigned ERR_THRESH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din_valid_i,
   input  logic        din_i,
   input  logic        clr_cnt_i,
   output logic        locked_o,
   output logic        err_o,
   output logic [31:0] err_cnt_o,
   output logic [31:0] bit_cnt_o
);
   state_e      state_q;
   logic [15:0] cnt_q, win_q, werr_q;
   logic [31:0] err_cnt_q, bit_cnt_q;
   logic        locked_q, err_q;
   logic        p, nz, mis, sel_p, drop;

   always_comb begin
      sel_p = state_q == LOCKED;
      mis   = din_i ^ p;
      drop  = din_valid_i && sel_p && mis && werr_q == 16'(ERR_THRESH - 1);
   end

   prbs26_pred u_pred (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_i (din_valid_i),
      .clear_i (drop),
      .sel_p_i (sel_p),
      .din_i   (din_i),
      .p_o     (p),
      .nz_o    (nz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         win_q     <= '0;
         werr_q    <= '0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (din_valid_i) begin
            case (state_q)
               FILL: begin
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q == 16'(PRBS26_LEN - 1)) begin
                     state_q <= ACQ;
                     cnt_q   <= '0;
                  end
               end
               ACQ: begin
                  if (!mis && nz) begin
                     cnt_q <= cnt_q + 16'd1;
                     if (cnt_q == 16'(LOCK_CNT - 1)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        cnt_q    <= '0;
                        win_q    <= '0;
                        werr_q   <= '0;
                     end
                  end else cnt_q <= '0;
               end
               LOCKED: begin
                  err_q     <= mis;
                  err_cnt_q <= mis ? sat_inc(err_cnt_q) : err_cnt_q;
                  bit_cnt_q <= sat_inc(bit_cnt_q);
                  win_q     <= win_q + 16'd1;
                  werr_q    <= werr_q + {15'd0, mis};
                  if (win_q == 16'(ERR_WIN - 1)) begin
                     win_q  <= '0;
                     werr_q <= '0;
                  end
                  // threshold beats a same-cycle window rollover
                  if (drop) begin
                     state_q  <= FILL;
                     locked_q <= 1'b0;
                     cnt_q    <= '0;
                     win_q    <= '0;
                     werr_q   <= '0;
                  end
               end
               default: state_q <= FILL;
            endcase
         end
         if (clr_cnt_i) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
         end
      end
   end

   assign locked_o  = locked_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
   assign bit_cnt_o = bit_cnt_q;
endmodule
